// File: rtl/packet_pkg.sv
// Shared packet-path types and default sizes for the switch and its port sinks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package packet_pkg;

    // Default payload width of a switch packet.
    localparam int PKT_DATA_W = 8;

    // Default number of entries in a port sink FIFO.
    localparam int SINK_DEPTH = 4;

    // Default width of the sink's delivery counters.
    localparam int SINK_CNT_W = 16;

    // FIFO operation for one cycle, formed as {push, pop}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sink_fifo.sv
// First-word-fall-through FIFO holding one switch port's packets; head valid the cycle after a push into an empty FIFO.
// Latency: 1 cycle from push to head visible; pop takes effect at the same edge.
// Backpressure: none internally; the caller must only push when not full (or full with a pop) and pop when not empty.
module sink_fifo
    import packet_pkg::*;
#(
    parameter int DATA_W = PKT_DATA_W,
    parameter int DEPTH  = SINK_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_dat_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [DATA_W-1:0]        head_o
);

    // DEPTH is a power of two and at least 2, so pointers wrap on their own
    // and the level counter needs exactly one bit more than a pointer.
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;

    fifo_op_e op;

    // Next-state for pointers, level and the registered full/empty flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        op       = fifo_op_e'({push_i, pop_i});
        case (op)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                level_d  = level_q + LW'(1);
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                level_d  = level_q - LW'(1);
            end
            FIFO_BOTH: begin
                // Occupancy unchanged; both ends advance.
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: begin
            end
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Control state; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload storage is deliberately not reset; empty_q masks stale entries.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Head is read straight from storage and forced to zero while empty so
    // the output is clean out of reset.
    always_comb begin
        head_o = '0;
        if (!empty_q) begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/switch_port_sink.sv
// Egress sink for one switch port: buffers packets in a FWFT FIFO and counts accepted/dropped packets.
// Latency: 1 cycle from sw_valid_i to rd_valid_o when the FIFO is empty.
// Backpressure: consumer stalls via rd_ready_i; the switch cannot be stalled, so packets arriving at a full FIFO with no pop are dropped.
module switch_port_sink
    import packet_pkg::*;
#(
    parameter int DATA_W = PKT_DATA_W,
    parameter int DEPTH  = SINK_DEPTH,
    parameter int CNT_W  = SINK_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sw_valid_i,
    input  logic [DATA_W-1:0]        sw_data_i,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [CNT_W-1:0]         rx_count_o,
    output logic [CNT_W-1:0]         drop_count_o,
    output logic                     overflow_o,
    input  logic                     clear_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;

    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q,      ovf_d;

    // Accept/drop decision: a full FIFO still accepts when the head leaves
    // in the same cycle, since the freed slot is reused at that edge.
    always_comb begin
        pop  = !fifo_empty && rd_ready_i;
        push = sw_valid_i && (!fifo_full || pop);
        drop = sw_valid_i && fifo_full && !pop;
    end

    sink_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (sw_data_i),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level_o),
        .head_o     (rd_data_o)
    );

    // Saturating counters and sticky overflow; clear wins over any increment.
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (clear_i) begin
            rx_cnt_d   = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (push && (rx_cnt_q != CNT_MAX)) begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
            if (drop && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_valid_o   = !fifo_empty;
    assign full_o       = fifo_full;
    assign empty_o      = fifo_empty;
    assign rx_count_o   = rx_cnt_q;
    assign drop_count_o = drop_cnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_switch_port_sink.sv
// Directed bench for switch_port_sink: default instance plus a 2-bit-counter instance sharing stimulus.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: rd_ready_i held low to fill the FIFO, high to drain it.
module tb_switch_port_sink;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_valid;
    logic [7:0] sw_data;
    logic       rd_ready;
    logic       clear;

    logic        rd_valid,   s_rd_valid;
    logic [7:0]  rd_data,    s_rd_data;
    logic [2:0]  level,      s_level;
    logic        full,       s_full;
    logic        empty,      s_empty;
    logic [15:0] rx_count,   drop_count;
    logic [1:0]  s_rx_count, s_drop_count;
    logic        overflow,   s_overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] burst [4];
    logic [7:0] fill2 [4];
    logic [7:0] drain2 [4];

    always #5 clk = ~clk;

    switch_port_sink dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_valid_i   (sw_valid),
        .sw_data_i    (sw_data),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .rd_ready_i   (rd_ready),
        .level_o      (level),
        .full_o       (full),
        .empty_o      (empty),
        .rx_count_o   (rx_count),
        .drop_count_o (drop_count),
        .overflow_o   (overflow),
        .clear_i      (clear)
    );

    switch_port_sink #(.DATA_W(8), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_valid_i   (sw_valid),
        .sw_data_i    (sw_data),
        .rd_valid_o   (s_rd_valid),
        .rd_data_o    (s_rd_data),
        .rd_ready_i   (rd_ready),
        .level_o      (s_level),
        .full_o       (s_full),
        .empty_o      (s_empty),
        .rx_count_o   (s_rx_count),
        .drop_count_o (s_drop_count),
        .overflow_o   (s_overflow),
        .clear_i      (clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        burst  = '{8'hA0, 8'hB0, 8'hFF, 8'h33};
        fill2  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain2 = '{8'h22, 8'h33, 8'h44, 8'hDD};

        rst_n    = 1'b0;
        sw_valid = 1'b0;
        sw_data  = 8'h00;
        rd_ready = 1'b0;
        clear    = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_rx", rx_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        // Single packet, one-cycle latency, one-cycle visibility
        sw_valid = 1'b1; sw_data = 8'hA0; rd_ready = 1'b1;
        tick();
        sw_valid = 1'b0;
        check("single_valid", rd_valid, 1);
        check("single_data", rd_data, 8'hA0);
        check("single_rx", rx_count, 1);
        check("single_level", level, 1);
        tick();
        check("single_valid_gone", rd_valid, 0);
        check("single_empty", empty, 1);

        // Burst fill with consumer stalled
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sw_valid = 1'b1; sw_data = burst[i];
            tick();
        end
        sw_valid = 1'b0;
        check("fill_full", full, 1);
        check("fill_level", level, 4);
        check("fill_rx", rx_count, 5);
        check("fill_head", rd_data, 8'hA0);

        // Overflow: packet EE dropped, contents unchanged
        sw_valid = 1'b1; sw_data = 8'hEE;
        tick();
        sw_valid = 1'b0;
        check("ovf_drop", drop_count, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_level", level, 4);
        check("ovf_head", rd_data, 8'hA0);
        check("ovf_rx", rx_count, 5);

        // Drain in order
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", rd_valid, 1);
            check($sformatf("drain_data%0d", i), rd_data, burst[i]);
            tick();
        end
        check("drain_empty", empty, 1);
        check("drain_valid_low", rd_valid, 0);
        check("drain_level", level, 0);

        // Full with simultaneous pop: DD accepted, level stays 4
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sw_valid = 1'b1; sw_data = fill2[i];
            tick();
        end
        check("fill2_full", full, 1);
        sw_valid = 1'b1; sw_data = 8'hDD; rd_ready = 1'b1;
        tick();
        sw_valid = 1'b0;
        check("fullpop_level", level, 4);
        check("fullpop_drop", drop_count, 1);
        check("fullpop_head", rd_data, 8'h22);
        check("fullpop_rx", rx_count, 10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain2_data%0d", i), rd_data, drain2[i]);
            tick();
        end
        check("drain2_empty", empty, 1);
        check("sat_rx_pre", s_rx_count, 3);

        // Clear with a same-cycle push: counters become 0, packet still stored
        clear = 1'b1; sw_valid = 1'b1; sw_data = 8'h55;
        tick();
        clear = 1'b0;
        check("clr_rx", rx_count, 0);
        check("clr_sat_rx", s_rx_count, 0);
        check("clr_drop", drop_count, 0);
        check("clr_ovf", overflow, 0);
        check("clr_sat_ovf", s_overflow, 0);
        check("clr_level", level, 1);
        check("clr_head", rd_data, 8'h55);

        // Five packets streamed through: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            sw_data = 8'h60 + 8'(i);
            tick();
        end
        check("stream_rx", rx_count, 5);
        check("stream_sat_rx", s_rx_count, 3);
        check("stream_level", level, 1);
        check("stream_head", rd_data, 8'h64);
        clear = 1'b1; sw_data = 8'h66;
        tick();
        clear = 1'b0; sw_valid = 1'b0;
        check("clr2_rx", rx_count, 0);
        check("clr2_sat_rx", s_rx_count, 0);
        tick();
        check("clr2_empty", empty, 1);

        // Reset mid-stream with 3 entries queued
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw_valid = 1'b1; sw_data = 8'h01 + 8'(i);
            tick();
        end
        check("pre_rst_level", level, 3);
        sw_data = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_rx", rx_count, 0);
        tick();
        tick();
        check("in_rst_level", level, 0);
        rst_n = 1'b1; sw_data = 8'hCC; sw_valid = 1'b1; rd_ready = 1'b1;
        tick();
        sw_valid = 1'b0;
        check("post_rst_valid", rd_valid, 1);
        check("post_rst_data", rd_data, 8'hCC);
        check("post_rst_level", level, 1);
        check("post_rst_rx", rx_count, 1);
        tick();
        check("post_rst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
